// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: opcode constants and the
// result-source selector produced by the opcode decoder.
package writeback_stage_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_11110 = 5'b11110;

    typedef enum logic [1:0] {
        SRC_ALU,
        SRC_MEM,
        SRC_LINK
    } wb_src_e;

endpackage

// File: rtl/writeback_stage_decode.sv
// Combinational opcode decoder: whether the instruction writes the register
// file, which result feeds the write, and the destination index.
module wb_decode
    import writeback_stage_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LINK_REG       = 31
) (
    input  logic [9:0]                opfield_i,
    output logic                      writes_o,
    output wb_src_e                   src_o,
    output logic [REG_ADDR_WIDTH-1:0] dest_o
);

    logic [4:0] opcode;
    logic [4:0] rd;

    assign opcode = opfield_i[9:5];
    assign rd     = opfield_i[4:0];

    always_comb begin
        writes_o = 1'b0;
        src_o    = SRC_ALU;
        dest_o   = REG_ADDR_WIDTH'(rd);
        case (opcode)
            OP_RTYPE, OP_ADDI, OP_11110: begin
                writes_o = 1'b1;
            end
            OP_LW: begin
                writes_o = 1'b1;
                src_o    = SRC_MEM;
            end
            OP_JAL: begin
                writes_o = 1'b1;
                src_o    = SRC_LINK;
                dest_o   = REG_ADDR_WIDTH'(LINK_REG);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Registered writeback stage: arbitrates the register-file write port between
// the pipeline and a one-entry buffer of late multiply/divide results.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LINK_REG       = 31,
    parameter int STATUS_REG     = 30,
    parameter int MD_EXC_CODE    = 4,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [31:0]               in_instruction,
    input  logic [DATA_WIDTH-1:0]     in_alu_result,
    input  logic [DATA_WIDTH-1:0]     in_mem_data,
    input  logic [DATA_WIDTH-1:0]     in_pc_plus1,
    input  logic                      md_valid,
    output logic                      md_ready,
    input  logic [REG_ADDR_WIDTH-1:0] md_rd,
    input  logic [DATA_WIDTH-1:0]     md_result,
    input  logic                      md_exception,
    output logic                      wr_en,
    output logic [REG_ADDR_WIDTH-1:0] wr_reg,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      stall_req
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic                      decWrites;
    wb_src_e                   decSrc;
    logic [REG_ADDR_WIDTH-1:0] decDest;
    logic                      unusedInstrBits;

    logic [DATA_WIDTH-1:0]     pipeData;
    logic                      pipeWrite;
    logic [REG_ADDR_WIDTH-1:0] mdDest;
    logic [DATA_WIDTH-1:0]     mdData;
    logic                      mdKeep;
    logic                      starved;

    logic                      bufFull_q, bufFull_d;
    logic [REG_ADDR_WIDTH-1:0] bufReg_q, bufReg_d;
    logic [DATA_WIDTH-1:0]     bufData_q, bufData_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      wrEn_q, wrEn_d;
    logic [REG_ADDR_WIDTH-1:0] wrReg_q, wrReg_d;
    logic [DATA_WIDTH-1:0]     wrData_q, wrData_d;
    logic                      stallReq_q, stallReq_d;

    assign unusedInstrBits = ^in_instruction[21:0];

    wb_decode #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .LINK_REG      (LINK_REG)
    ) u_decode (
        .opfield_i(in_instruction[31:22]),
        .writes_o (decWrites),
        .src_o    (decSrc),
        .dest_o   (decDest)
    );

    assign md_ready  = ~bufFull_q;
    assign wr_en     = wrEn_q;
    assign wr_reg    = wrReg_q;
    assign wr_data   = wrData_q;
    assign stall_req = stallReq_q;

    always_comb begin
        case (decSrc)
            SRC_MEM:  pipeData = in_mem_data;
            SRC_LINK: pipeData = in_pc_plus1;
            default:  pipeData = in_alu_result;
        endcase

        pipeWrite = in_valid && decWrites && (decDest != '0);
        mdDest    = md_exception ? REG_ADDR_WIDTH'(STATUS_REG) : md_rd;
        mdData    = md_exception ? DATA_WIDTH'(MD_EXC_CODE) : md_result;
        mdKeep    = md_valid && md_ready && (md_exception || (md_rd != '0));
        starved   = bufFull_q && pipeWrite;

        bufFull_d = bufFull_q;
        bufReg_d  = bufReg_q;
        bufData_d = bufData_q;
        wrEn_d    = 1'b0;
        wrReg_d   = wrReg_q;
        wrData_d  = wrData_q;

        // Pipe wins; a buffered entry beats a fresh result, which may only
        // bypass straight to the port when nothing else wants it.
        if (pipeWrite) begin
            wrEn_d   = 1'b1;
            wrReg_d  = decDest;
            wrData_d = pipeData;
            if (mdKeep) begin
                bufFull_d = 1'b1;
                bufReg_d  = mdDest;
                bufData_d = mdData;
            end
        end else if (bufFull_q) begin
            wrEn_d    = 1'b1;
            wrReg_d   = bufReg_q;
            wrData_d  = bufData_q;
            bufFull_d = 1'b0;
        end else if (mdKeep) begin
            wrEn_d   = 1'b1;
            wrReg_d  = mdDest;
            wrData_d = mdData;
        end

        if (starved) begin
            cnt_d = (cnt_q == CNT_W'(STARVE_LIMIT)) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
        stallReq_d = starved && (cnt_q == CNT_W'(STARVE_LIMIT - 1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bufFull_q  <= 1'b0;
            bufReg_q   <= '0;
            bufData_q  <= '0;
            cnt_q      <= '0;
            wrEn_q     <= 1'b0;
            wrReg_q    <= '0;
            wrData_q   <= '0;
            stallReq_q <= 1'b0;
        end else begin
            bufFull_q  <= bufFull_d;
            bufReg_q   <= bufReg_d;
            bufData_q  <= bufData_d;
            cnt_q      <= cnt_d;
            wrEn_q     <= wrEn_d;
            wrReg_q    <= wrReg_d;
            wrData_q   <= wrData_d;
            stallReq_q <= stallReq_d;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a random
// run compared against a queue-based reference model of the writeback rules.
module tb_writeback_stage;

    localparam int DW     = 32;
    localparam int RA     = 5;
    localparam int LIMIT  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [31:0]   in_instruction;
    logic [DW-1:0] in_alu_result;
    logic [DW-1:0] in_mem_data;
    logic [DW-1:0] in_pc_plus1;
    logic          md_valid;
    logic          md_ready;
    logic [RA-1:0] md_rd;
    logic [DW-1:0] md_result;
    logic          md_exception;
    logic          wr_en;
    logic [RA-1:0] wr_reg;
    logic [DW-1:0] wr_data;
    logic          stall_req;

    always #5 clock = ~clock;

    writeback_stage #(
        .DATA_WIDTH    (DW),
        .REG_ADDR_WIDTH(RA),
        .LINK_REG      (31),
        .STATUS_REG    (30),
        .MD_EXC_CODE   (4),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_instruction(in_instruction),
        .in_alu_result (in_alu_result),
        .in_mem_data   (in_mem_data),
        .in_pc_plus1   (in_pc_plus1),
        .md_valid      (md_valid),
        .md_ready      (md_ready),
        .md_rd         (md_rd),
        .md_result     (md_result),
        .md_exception  (md_exception),
        .wr_en         (wr_en),
        .wr_reg        (wr_reg),
        .wr_data       (wr_data),
        .stall_req     (stall_req)
    );

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } entry_t;

    entry_t      pend[$];
    logic        expWrEn;
    logic [4:0]  expWrReg;
    logic [31:0] expWrData;
    logic        expStall;
    int          held;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd);
        return {op, rd, 22'h2A5A5};
    endfunction

    function automatic bit refDecode(input logic [31:0] ins, input logic [31:0] alu,
                                     input logic [31:0] mem, input logic [31:0] pc,
                                     output logic [4:0] dest, output logic [31:0] data);
        dest = ins[26:22];
        data = alu;
        case (ins[31:27])
            5'b00000, 5'b00101, 5'b11110: return 1'b1;
            5'b01000: begin data = mem; return 1'b1; end
            5'b00011: begin dest = 5'd31; data = pc; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelClear();
        pend.delete();
        expWrEn   = 1'b0;
        expWrReg  = '0;
        expWrData = '0;
        expStall  = 1'b0;
        held      = 0;
    endtask

    // Drives one cycle of inputs, advances the model, lands on the next negedge.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] pc, input logic mv,
                        input logic [4:0] mrd, input logic [31:0] mres, input logic mexc);
        logic [4:0]  pDest;
        logic [31:0] pData;
        bit          pipe;
        bit          hadPending;
        bit          useful;
        entry_t      e;
        entry_t      m;
        in_valid       = iv;
        in_instruction = ins;
        in_alu_result  = alu;
        in_mem_data    = mem;
        in_pc_plus1    = pc;
        md_valid       = mv;
        md_rd          = mrd;
        md_result      = mres;
        md_exception   = mexc;

        pipe       = iv && refDecode(ins, alu, mem, pc, pDest, pData) && (pDest != 0);
        hadPending = (pend.size() != 0);
        useful     = mv && !hadPending && (mexc || mrd != 0);
        m.dest     = mexc ? 5'd30 : mrd;
        m.data     = mexc ? 32'd4 : mres;
        expStall   = 1'b0;
        if (pipe) begin
            expWrEn = 1'b1; expWrReg = pDest; expWrData = pData;
            if (hadPending) begin
                held++;
                if (held == LIMIT) expStall = 1'b1;
            end
            if (useful) pend.push_back(m);
        end else if (hadPending) begin
            e = pend.pop_front();
            expWrEn = 1'b1; expWrReg = e.dest; expWrData = e.data;
        end else if (useful) begin
            expWrEn = 1'b1; expWrReg = m.dest; expWrData = m.data;
        end else begin
            expWrEn = 1'b0;
        end
        if (pend.size() == 0) held = 0;

        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 0; in_instruction = 0; in_alu_result = 0; in_mem_data = 0;
        in_pc_plus1 = 0; md_valid = 0; md_rd = 0; md_result = 0; md_exception = 0;
        #1 reset = 1'b0;
        modelClear();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({wr_en, wr_reg, wr_data, stall_req} !== '0)
            $display("[TB] FAIL reset_outputs: got en=%b reg=%0d data=%h stall=%b, want all 0",
                     wr_en, wr_reg, wr_data, stall_req);
        else passed++;
        checks++;
        if (md_ready !== 1'b1) $display("[TB] FAIL reset_md_ready: got %b want 1", md_ready);
        else passed++;
    endtask

    task automatic test_load();
        step(1'b1, mk(5'b01000, 5'd5), 32'h1111, 32'hDEADBEEF, 32'h0, 1'b0, '0, '0, 1'b0);
        checks++;
        if ({wr_en, wr_reg, wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
            $display("[TB] FAIL lw_r5: got en=%b reg=%0d data=%h, want 1/5/deadbeef",
                     wr_en, wr_reg, wr_data);
        else passed++;
    endtask

    task automatic test_jal_r0();
        step(1'b1, mk(5'b00011, 5'd4), 32'h7, 32'h8, 32'h40, 1'b0, '0, '0, 1'b0);
        checks++;
        if ({wr_en, wr_reg, wr_data} !== {1'b1, 5'd31, 32'h40})
            $display("[TB] FAIL jal_link: got en=%b reg=%0d data=%h, want 1/31/40",
                     wr_en, wr_reg, wr_data);
        else passed++;
        step(1'b1, mk(5'b00101, 5'd0), 32'h55, 32'h0, 32'h0, 1'b0, '0, '0, 1'b0);
        checks++;
        if (wr_en !== 1'b0) $display("[TB] FAIL addi_r0: got wr_en=%b want 0", wr_en);
        else passed++;
        step(1'b1, mk(5'b00110, 5'd6), 32'h55, 32'h0, 32'h0, 1'b0, '0, '0, 1'b0);
        checks++;
        if (wr_en !== 1'b0) $display("[TB] FAIL nonwriting_op: got wr_en=%b want 0", wr_en);
        else passed++;
    endtask

    task automatic test_bypass();
        step(1'b0, '0, '0, '0, '0, 1'b1, 5'd7, 32'd12, 1'b0);
        checks++;
        if ({wr_en, wr_reg, wr_data, md_ready} !== {1'b1, 5'd7, 32'd12, 1'b1})
            $display("[TB] FAIL md_bypass: got en=%b reg=%0d data=%h rdy=%b, want 1/7/c/1",
                     wr_en, wr_reg, wr_data, md_ready);
        else passed++;
        idle();
        checks++;
        if (wr_en !== 1'b0) $display("[TB] FAIL bypass_no_replay: got wr_en=%b want 0", wr_en);
        else passed++;
    endtask

    task automatic test_buffer();
        step(1'b1, mk(5'b00000, 5'd3), 32'h33, '0, '0, 1'b1, 5'd9, 32'h99, 1'b0);
        checks++;
        if ({wr_en, wr_reg, wr_data, md_ready} !== {1'b1, 5'd3, 32'h33, 1'b0})
            $display("[TB] FAIL buffer_fill: got en=%b reg=%0d data=%h rdy=%b, want 1/3/33/0",
                     wr_en, wr_reg, wr_data, md_ready);
        else passed++;
        idle();
        checks++;
        if ({wr_en, wr_reg, wr_data, md_ready} !== {1'b1, 5'd9, 32'h99, 1'b1})
            $display("[TB] FAIL buffer_drain: got en=%b reg=%0d data=%h rdy=%b, want 1/9/99/1",
                     wr_en, wr_reg, wr_data, md_ready);
        else passed++;
    endtask

    task automatic test_back_to_back();
        step(1'b1, mk(5'b00000, 5'd3), 32'h3, '0, '0, 1'b1, 5'd9, 32'hABC, 1'b0);
        for (int i = 1; i <= LIMIT; i++) begin
            step(1'b1, mk(5'b11110, 5'(i)), 32'(i), '0, '0, 1'b0, '0, '0, 1'b0);
            checks++;
            if ({stall_req, wr_reg, md_ready} !== {(i == LIMIT), 5'(i), 1'b0})
                $display("[TB] FAIL starve_%0d: got stall=%b reg=%0d rdy=%b, want %b/%0d/0",
                         i, stall_req, wr_reg, md_ready, (i == LIMIT), i);
            else passed++;
        end
        idle();
        checks++;
        if ({wr_en, wr_reg, wr_data, stall_req, md_ready} !== {1'b1, 5'd9, 32'hABC, 1'b0, 1'b1})
            $display("[TB] FAIL bubble_drain: got en=%b reg=%0d data=%h stall=%b rdy=%b, want 1/9/abc/0/1",
                     wr_en, wr_reg, wr_data, stall_req, md_ready);
        else passed++;
    endtask

    task automatic test_exception();
        step(1'b0, '0, '0, '0, '0, 1'b1, 5'd9, 32'h1234, 1'b1);
        checks++;
        if ({wr_en, wr_reg, wr_data} !== {1'b1, 5'd30, 32'd4})
            $display("[TB] FAIL md_exception: got en=%b reg=%0d data=%h, want 1/30/4",
                     wr_en, wr_reg, wr_data);
        else passed++;
        step(1'b0, '0, '0, '0, '0, 1'b1, 5'd0, 32'h77, 1'b0);
        checks++;
        if (wr_en !== 1'b0) $display("[TB] FAIL md_r0_discard: got wr_en=%b want 0", wr_en);
        else passed++;
    endtask

    task automatic test_reset_midop();
        step(1'b1, mk(5'b00000, 5'd3), 32'h3, '0, '0, 1'b1, 5'd12, 32'hBAD, 1'b0);
        md_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({wr_en, md_ready} !== 2'b01)
            $display("[TB] FAIL reset_midop: got en=%b rdy=%b, want 0/1", wr_en, md_ready);
        else passed++;
        @(negedge clock);
        reset = 1'b1;
        modelClear();
        idle();
        checks++;
        if ({wr_en, md_ready} !== 2'b01)
            $display("[TB] FAIL no_replay_after_reset: got en=%b rdy=%b, want 0/1", wr_en, md_ready);
        else passed++;
    endtask

    task automatic test_random();
        logic [4:0]  ops [7] = '{5'b00000, 5'b00101, 5'b01000, 5'b00011, 5'b11110, 5'b00001, 5'b10101};
        logic        iv;
        logic [31:0] ins;
        logic        mv = 1'b0;
        logic [4:0]  mrd = '0;
        logic [31:0] mres = '0;
        logic        mexc = 1'b0;
        bit          holding = 1'b0;
        bit          accepted;
        for (int c = 0; c < 400; c++) begin
            iv  = expStall ? 1'b0 : ($urandom_range(0, 3) != 0);
            ins = mk(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)));
            if (!holding) begin
                mv   = ($urandom_range(0, 2) == 0);
                mrd  = 5'($urandom_range(0, 3));
                mres = $urandom;
                mexc = ($urandom_range(0, 4) == 0);
            end
            accepted = (pend.size() == 0);
            step(iv, ins, $urandom, $urandom, $urandom, mv, mrd, mres, mexc);
            holding = mv && !accepted;
            checks++;
            if ({wr_en, wr_reg, wr_data, stall_req, md_ready} !==
                {expWrEn, expWrReg, expWrData, expStall, (pend.size() == 0)})
                $display("[TB] FAIL random_c%0d: got en=%b reg=%0d data=%h stall=%b rdy=%b, want en=%b reg=%0d data=%h stall=%b rdy=%b",
                         c, wr_en, wr_reg, wr_data, stall_req, md_ready,
                         expWrEn, expWrReg, expWrData, expStall, (pend.size() == 0));
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_jal_r0();
        test_bypass();
        test_buffer();
        test_back_to_back();
        test_exception();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Parametrised, registered writeback stage for the pipelined processor. Captures the MEM/WB bundle, decodes the opcode to choose destination register and result source, and drives the register-file write port plus a forwarding tap. Merges late results from the multi-cycle multiply/divide unit through a one-entry holding buffer, with starvation protection that requests a pipeline bubble.

## Interface
Parameters:
- DATA_WIDTH, 32, width of results and register-file data
- REG_ADDR_WIDTH, 5, register index width
- LINK_REG, 31, destination for jal
- STATUS_REG, 30, destination for multdiv exception codes
- MD_EXC_CODE, 4, value written to STATUS_REG on a multdiv exception
- STARVE_LIMIT, 4, buffer-occupied cycles before a bubble is requested (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  MEM/WB bundle valid this cycle
- in_instruction  in  32  instruction; opcode is [31:27], rd is [26:22]
- in_alu_result  in  DATA_WIDTH  ALU/immediate result
- in_mem_data  in  DATA_WIDTH  load data
- in_pc_plus1  in  DATA_WIDTH  link value for jal
- md_valid  in  1  multdiv result offered
- md_ready  out  1  block can accept a multdiv result
- md_rd  in  REG_ADDR_WIDTH  multdiv destination
- md_result  in  DATA_WIDTH  multdiv result
- md_exception  in  1  multdiv overflow / divide-by-zero
- wr_en  out  1  register-file write enable
- wr_reg  out  REG_ADDR_WIDTH  write index
- wr_data  out  DATA_WIDTH  write data
- stall_req  out  1  request upstream to send one bubble

## Operation
- Writing opcodes: 00000 (R-type) and 00101 (addi) -> rd, alu_result; 01000 (lw) -> rd, mem_data; 00011 (jal) -> LINK_REG, pc_plus1; 11110 -> rd, alu_result. All other opcodes do not write.
- Pipe write: in_valid, writing opcode, and destination ≠ 0. A write to r0 is dropped and frees the slot.
- Multdiv handshake: transfer when md_valid && md_ready. md_ready = ~buf_full (combinational from state only). If md_exception, destination = STATUS_REG, data = MD_EXC_CODE zero-extended; md_rd = 0 without exception is discarded.
- Slot arbitration per cycle, priority: pipe write > buffered md > newly transferred md. A new md takes the slot directly (bypass) only when no pipe write and buffer empty; otherwise it enters the buffer. A buffered entry drains in any cycle without a pipe write.
- Starvation counter: increments each cycle buf_full and not draining; clears on drain or when empty. At count = STARVE_LIMIT−1, stall_req registers high for exactly one cycle; upstream guarantees in_valid=0 in the cycle after stall_req is seen, and the buffer drains then.
- Buffered entry and pipe write same destination: pipe write occurs first, buffered write after (program order: multdiv issued earlier commits later; the compiler/hazard unit forbids WAW on pending multdiv, so no check here).

## Timing
- Decision made from inputs in cycle N; wr_en/wr_reg/wr_data registered, visible in cycle N+1. Latency 1.
- Reset values: wr_en 0, wr_reg 0, wr_data 0, stall_req 0, buffer empty (md_ready 1 once reset deasserts), counter 0.
- Reset asserted mid-operation discards the buffered entry and the pending output write; nothing is replayed.
- Buffer full and md_valid high: md_ready 0, producer holds; no loss.

## Structure
- Shared package: opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_JAL, OP_11110), write-source select enum.
- One sub-module natural: wb_decode (combinational opcode -> write-enable, source select, destination), reused by hazard logic.

## Test plan
- Reset release: all outputs 0, md_ready 1; lw r5 with mem_data 0xDEADBEEF -> next cycle wr_en 1, wr_reg 5, wr_data 0xDEADBEEF.
- jal with pc_plus1 0x40 -> wr_reg 31, wr_data 0x40; addi to r0 -> wr_en 0.
- Idle pipe, md_valid rd 7 result 12 -> bypass, wr_reg 7 next cycle, buffer stays empty.
- Pipe writes r3 while md arrives rd 9 -> r3 written, md buffered, md_ready 0; next idle cycle writes r9, md_ready 1.
- Back-to-back pipe writes with buffer full -> stall_req pulses one cycle after STARVE_LIMIT cycles; bubble cycle drains buffer.
- md_exception with rd 9 -> wr_reg 30, wr_data 4; reset asserted while buffer full -> buffer cleared, no write after release.
